edf_arbiter: RTL and testbench

EDF_ARBITER -- requirements
Module: edf_arbiter

---
 rtl/edf_arbiter.sv | 138 +++++++++++++
 tb/tb_edf_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/edf_arbiter.sv
// Earliest-deadline-first arbiter: scans pending+enabled gateway cells one index
// per cycle, presents the earliest absolute deadline to the core, and issues a claim.
module edf_arbiter #(
  parameter int NrIrqs  = 8,
  parameter int TsWidth = 64,
  parameter int IdWidth = $clog2(NrIrqs)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NrIrqs-1:0]         ip_i,
  input  logic [NrIrqs-1:0]         en_i,
  input  logic [NrIrqs*TsWidth-1:0] dl_i,
  input  logic                      claim_req_i,
  output logic                      irq_o,
  output logic [IdWidth-1:0]        irq_id_o,
  output logic [TsWidth-1:0]        irq_dl_o,
  output logic [NrIrqs-1:0]         claim_o,
  output logic [1:0]                state_o
);

  // Handshake: irq_o is held high with a stable id/deadline while presenting;
  // a one-cycle claim_req_i in that window is answered by a one-cycle one-hot
  // claim_o on the following cycle, and is ignored in every other state.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    PRESENT = 2'd2,
    CLAIM   = 2'd3
  } state_t;

  localparam logic [IdWidth-1:0] LastIdx = IdWidth'(NrIrqs - 1);

  state_t               state, state_n;
  logic [IdWidth-1:0]   idx, idx_n;
  logic [NrIrqs-1:0]    snap, snap_n;
  logic                 have_best, have_best_n;
  logic [IdWidth-1:0]   best_id, best_id_n;
  logic [TsWidth-1:0]   best_dl, best_dl_n;

  logic [NrIrqs-1:0]    cand;
  logic [TsWidth-1:0]   dl_arr [NrIrqs];
  logic                 take;

  assign cand = ip_i & en_i;

  for (genvar k = 0; k < NrIrqs; k++) begin : g_unpack
    assign dl_arr[k] = dl_i[k*TsWidth +: TsWidth];
  end

  // Strict less-than keeps the lower index on equal deadlines.
  assign take = snap[idx] && (!have_best || (dl_arr[idx] < best_dl));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      idx       <= '0;
      snap      <= '0;
      have_best <= 1'b0;
      best_id   <= '0;
      best_dl   <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      snap      <= snap_n;
      have_best <= have_best_n;
      best_id   <= best_id_n;
      best_dl   <= best_dl_n;
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    snap_n      = snap;
    have_best_n = have_best;
    best_id_n   = best_id;
    best_dl_n   = best_dl;
    case (state)
      IDLE: begin
        if (|cand) begin
          state_n     = SCAN;
          idx_n       = '0;
          snap_n      = cand;
          have_best_n = 1'b0;
        end
      end
      SCAN: begin
        if (cand != snap) begin
          idx_n       = '0;
          snap_n      = cand;
          have_best_n = 1'b0;
        end else begin
          if (take) begin
            have_best_n = 1'b1;
            best_id_n   = idx;
            best_dl_n   = dl_arr[idx];
          end
          if (idx == LastIdx) begin
            idx_n   = '0;
            state_n = (take || have_best) ? PRESENT : IDLE;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      PRESENT: begin
        // Losing the presented candidate outranks a simultaneous claim.
        if (!cand[best_id]) begin
          state_n     = SCAN;
          idx_n       = '0;
          snap_n      = cand;
          have_best_n = 1'b0;
        end else if (claim_req_i) begin
          state_n = CLAIM;
        end else if (cand != snap) begin
          state_n     = SCAN;
          idx_n       = '0;
          snap_n      = cand;
          have_best_n = 1'b0;
        end
      end
      CLAIM: begin
        state_n     = IDLE;
        have_best_n = 1'b0;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign irq_o    = (state == PRESENT);
  assign irq_id_o = (state == PRESENT) ? best_id : '0;
  assign irq_dl_o = (state == PRESENT) ? best_dl : '0;
  assign claim_o  = (state == CLAIM) ? (NrIrqs'(1) << best_id) : '0;
  assign state_o  = state;

endmodule

// File: tb/tb_edf_arbiter.sv
// Directed bench for edf_arbiter (4 cells, 16-bit deadlines) with hand-computed
// expectations for presentation latency, ties, claims, preemption, masking and reset.
module tb_edf_arbiter;

  localparam int N  = 4;
  localparam int TW = 16;
  localparam int IW = 2;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SCAN    = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;
  localparam logic [1:0] S_CLAIM   = 2'd3;

  logic            clk;
  logic            rst;
  logic [N-1:0]    ip;
  logic [N-1:0]    en;
  logic [TW-1:0]   dlv [N];
  logic [N*TW-1:0] dl;
  logic            claim_req;
  logic            irq;
  logic [IW-1:0]   irq_id;
  logic [TW-1:0]   irq_dl;
  logic [N-1:0]    claim;
  logic [1:0]      state;

  int n_checks = 0;
  int n_errors = 0;

  assign dl = {dlv[3], dlv[2], dlv[1], dlv[0]};

  edf_arbiter #(.NrIrqs(N), .TsWidth(TW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .ip_i        (ip),
    .en_i        (en),
    .dl_i        (dl),
    .claim_req_i (claim_req),
    .irq_o       (irq),
    .irq_id_o    (irq_id),
    .irq_dl_o    (irq_dl),
    .claim_o     (claim),
    .state_o     (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_irq"},   64'(irq),    64'd0);
    check({tag, "_id"},    64'(irq_id), 64'd0);
    check({tag, "_dl"},    64'(irq_dl), 64'd0);
    check({tag, "_claim"}, 64'(claim),  64'd0);
    check({tag, "_state"}, 64'(state),  64'(S_IDLE));
  endtask

  task automatic check_present(input string tag, input int id, input int d);
    check({tag, "_irq"}, 64'(irq),    64'd1);
    check({tag, "_id"},  64'(irq_id), 64'(id));
    check({tag, "_dl"},  64'(irq_dl), 64'(d));
  endtask

  initial begin
    rst = 1'b1; ip = '0; en = '0; claim_req = 1'b0;
    for (int i = 0; i < N; i++) dlv[i] = '0;
    ticks(2);
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();
    check_idle_outputs("post_reset_idle");

    // basic: dl1=100, dl2=50 -> id 2 presented NrIrqs+1 cycles after raise
    en = 4'hF; dlv[1] = 16'd100; dlv[2] = 16'd50; ip = 4'b0110;
    ticks(4);
    check("basic_not_early", 64'(irq), 64'd0);
    tick();
    check_present("basic", 2, 50);
    tick();
    check_present("basic_stable", 2, 50);

    // claim id 2, gateway drops ip2 during the claim cycle
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
    check("claim_onehot", 64'(claim), 64'b0100);
    check("claim_irq",    64'(irq),   64'd0);
    check("claim_state",  64'(state), 64'(S_CLAIM));
    ip = 4'b0010;
    tick();
    check("after_claim_state", 64'(state), 64'(S_IDLE));
    check("after_claim_claim", 64'(claim), 64'd0);
    ticks(5);
    check_present("rescan_id1", 1, 100);

    // preemption: ip0 with earlier deadline
    dlv[0] = 16'd20; ip = 4'b0011;
    tick();
    check("preempt_drop", 64'(irq), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("preempt_no_claim", 64'(claim), 64'd0);
    end
    check("preempt_not_early", 64'(irq), 64'd0);
    tick();
    check_present("preempt", 0, 20);

    // tie: dl1 == dl3 -> lower index wins
    dlv[1] = 16'd70; dlv[3] = 16'd70; ip = 4'b1010;
    ticks(5);
    check_present("tie", 1, 70);

    // mask the presented id together with a claim request -> rescan, no claim
    en = 4'b1101; claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
    check("mask_state", 64'(state), 64'(S_SCAN));
    check("mask_claim", 64'(claim), 64'd0);
    check("mask_irq",   64'(irq),   64'd0);
    ticks(4);
    check_present("mask_rescan", 3, 70);

    // mask the last candidate -> empty scan back to idle
    en = 4'b0101; claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
    check("drop_claim", 64'(claim), 64'd0);
    check("drop_state", 64'(state), 64'(S_SCAN));
    ticks(4);
    check_idle_outputs("drop_idle");

    // claim request outside PRESENT is ignored
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
    check_idle_outputs("stray_claim");

    // reset at third scan cycle
    en = 4'hF; dlv[1] = 16'd100; dlv[2] = 16'd50; ip = 4'b0110;
    ticks(3);
    check("midscan_state", 64'(state), 64'(S_SCAN));
    rst = 1'b1;
    tick();
    check_idle_outputs("midscan_reset");
    rst = 1'b0;
    ticks(4);
    check("midscan_not_early", 64'(irq), 64'd0);
    tick();
    check_present("midscan_recover", 2, 50);

    // reset during CLAIM stops further claim pulses
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
    check("rstclaim_onehot", 64'(claim), 64'b0100);
    rst = 1'b1;
    tick();
    check_idle_outputs("rstclaim_reset");
    rst = 1'b0; ip = '0;
    ticks(2);
    check_idle_outputs("final_idle");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
